uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
Sits directly downstream of the UART receiver and consumes its byte stream (valid flag plus data byte). It assembles fixed 5-byte command frames: SOF, CMD, ADDR, DATA, CHK. On a good checksum it emits one decoded command as a single-cycle pulse to the I/O register logic. It flags checksum errors and inter-byte timeouts, and keeps a saturating error count.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame marker
TIMEOUT_CYCLES, 1_000_000, max clk cycles between bytes inside a frame (10 ms at 100 MHz)
ERR_CNT_WIDTH, 8, width of saturating error counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
i_data_vld  in  1  receiver byte-valid; level, stays high for many cycles per byte
i_rx_data  in  8  receiver byte; settles one cycle after i_data_vld rises
o_cmd_vld  out  1  one-cycle pulse, decoded command valid
o_cmd  out  8  command code, held until next o_cmd_vld
o_addr  out  8  address byte, held until next o_cmd_vld
o_wdata  out  8  data byte, held until next o_cmd_vld
o_chk_err  out  1  one-cycle pulse, checksum mismatch
o_timeout  out  1  one-cycle pulse, frame abandoned on timeout
o_err_cnt  out  ERR_CNT_WIDTH  saturating count of chk errors plus timeouts
o_busy  out  1  high whenever FSM is not in IDLE

Behaviour:
- Reset (async, active-high): all outputs 0, FSM to IDLE, timeout counter 0, edge-detect register 0.
- Byte strobe:
  - The block registers i_data_vld (vld_q).
  - Rising edge is detected in cycle N, when i_data_vld=1 and vld_q=0.
  - i_rx_data is captured at the end of cycle N+1; this is "byte accepted".
  - A level held high produces exactly one byte.
- FSM states: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK.
  - IDLE: a byte equal to SOF_BYTE moves to GET_CMD. Any other byte is ignored silently (no error, no count).
  - GET_CMD / GET_ADDR / GET_DATA: store the byte in a shadow register and advance.
    - A SOF_BYTE value here is treated as ordinary data; there is no resync.
  - GET_CHK: compare the byte with CMD^ADDR^DATA (shadow regs).
    - Match: copy shadows to o_cmd/o_addr/o_wdata and pulse o_cmd_vld.
    - Mismatch: pulse o_chk_err, outputs unchanged.
    - Both cases return to IDLE.
- Latency: o_cmd_vld / o_chk_err high in cycle N+2, where N is the rising-edge cycle of the CHK byte. Exactly one cycle wide.
- Timeout:
  - Counter is cleared in IDLE and on every accepted byte.
  - It increments every cycle in the other states.
  - When it reaches TIMEOUT_CYCLES-1: pulse o_timeout, go to IDLE, discard the partial frame.
  - If a byte is accepted in the same cycle the counter reaches TIMEOUT_CYCLES-1, the byte wins and no timeout is raised.
- o_err_cnt:
  - Increments by 1 on each o_chk_err or o_timeout pulse (the two are mutually exclusive by construction).
  - Saturates at all-ones and never wraps.
  - Cleared only by rst.
- Reset mid-frame: immediate return to IDLE, shadows and outputs cleared. A vld level still high after rst deasserts is not counted as a new byte unless it rises again.
- Back-to-back frames: a new SOF may arrive as soon as the FSM returns to IDLE. There are no dead cycles beyond the edge detect.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - the FSM state encoding (3-bit localparams);
  - the SOF_BYTE default;
  - frame length 5;
  - the command code constants used by the I/O register block (CMD_WR=8'h01, CMD_RD=8'h02).
- One natural sub-module, rx_byte_strobe: edge-detects i_data_vld, delays by one cycle, and outputs a one-cycle byte_stb plus the captured byte. The parser FSM, checksum and timeout stay in uart_cmd_parser.

Test Plan:
1. Bytes A5,01,10,3C,2D, each with vld held 651 cycles -> one o_cmd_vld pulse; o_cmd=01, o_addr=10, o_wdata=3C; o_err_cnt=0.
2. Bytes A5,01,10,3C,2E -> o_chk_err pulse, no o_cmd_vld, outputs keep previous values, o_err_cnt=1.
3. Garbage 00,FF,5A, then a valid frame A5,02,20,00,22 -> only one o_cmd_vld (cmd=02, addr=20, wdata=00), no errors.
4. A5,01, then idle for TIMEOUT_CYCLES (set 100 in bench) -> o_timeout pulse at exactly 100 cycles after the 01 capture, o_busy falls, o_err_cnt increments. A following full frame decodes correctly.
5. Assert rst during GET_ADDR with vld high -> all outputs 0, IDLE. After release no byte is taken until vld falls and rises again.
6. ERR_CNT_WIDTH=2, five bad-checksum frames -> o_err_cnt goes 1,2,3,3,3 (saturates).

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command frame parser and the I/O register block.
package uart_cmd_pkg;

  localparam logic [7:0]  SOF_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN        = 5;

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_CMD  = 3'd1,
    ST_GET_ADDR = 3'd2,
    ST_GET_DATA = 3'd3,
    ST_GET_CHK  = 3'd4
  } state_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_cmd_parser_rx_byte_strobe.sv
// Turns the receiver's level-style valid into a single byte strobe, one cycle after the rise,
// so the strobe lines up with the settled receiver data.
module rx_byte_strobe (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_vld_i,
  input  logic [7:0] rx_data_i,
  output logic       byte_stb_o,
  output logic [7:0] byte_o
);

  logic vld_q;
  logic arm_q;
  logic rise_q;

  // arm_q blocks a level that was already high when reset released from counting as a byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      arm_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      vld_q  <= data_vld_i;
      rise_q <= data_vld_i & ~vld_q & arm_q;
      if (!data_vld_i) arm_q <= 1'b1;
    end
  end

  assign byte_stb_o = rise_q;
  assign byte_o     = rx_data_i;

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles SOF/CMD/ADDR/DATA/CHK frames from the UART byte stream and emits decoded commands,
// checksum-error and timeout pulses, and a saturating error count.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE       = SOF_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned ERR_CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_data_vld,
  input  logic [7:0]               i_rx_data,
  output logic                     o_cmd_vld,
  output logic [7:0]               o_cmd,
  output logic [7:0]               o_addr,
  output logic [7:0]               o_wdata,
  output logic                     o_chk_err,
  output logic                     o_timeout,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt,
  output logic                     o_busy
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic       byte_stb;
  logic [7:0] byte_val;

  rx_byte_strobe u_strobe (
    .clk       (clk),
    .rst       (rst),
    .data_vld_i(i_data_vld),
    .rx_data_i (i_rx_data),
    .byte_stb_o(byte_stb),
    .byte_o    (byte_val)
  );

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [7:0]               cmd_sh_q, cmd_sh_d, addr_sh_q, addr_sh_d, data_sh_q, data_sh_d;
  logic [7:0]               cmd_q, cmd_d, addr_q, addr_d, wdata_q, wdata_d;
  logic                     cmd_vld_q, cmd_vld_d, chk_err_q, chk_err_d, timeout_q, timeout_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_sh_q  <= '0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      cmd_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cmd_vld_q <= 1'b0;
      chk_err_q <= 1'b0;
      timeout_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_sh_q  <= cmd_sh_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cmd_vld_q <= cmd_vld_d;
      chk_err_q <= chk_err_d;
      timeout_q <= timeout_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_sh_d  = cmd_sh_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cmd_vld_d = 1'b0;
    chk_err_d = 1'b0;
    timeout_d = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (byte_stb && byte_val == SOF_BYTE) state_d = ST_GET_CMD;
      end
      ST_GET_CMD: begin
        if (byte_stb) begin
          cmd_sh_d = byte_val;
          state_d  = ST_GET_ADDR;
        end
      end
      ST_GET_ADDR: begin
        if (byte_stb) begin
          addr_sh_d = byte_val;
          state_d   = ST_GET_DATA;
        end
      end
      ST_GET_DATA: begin
        if (byte_stb) begin
          data_sh_d = byte_val;
          state_d   = ST_GET_CHK;
        end
      end
      ST_GET_CHK: begin
        if (byte_stb) begin
          if (byte_val == frame_chk(cmd_sh_q, addr_sh_q, data_sh_q)) begin
            cmd_d     = cmd_sh_q;
            addr_d    = addr_sh_q;
            wdata_d   = data_sh_q;
            cmd_vld_d = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // An accepted byte in the terminal-count cycle takes priority over the timeout.
    if (state_q == ST_IDLE || byte_stb) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d     = '0;
      timeout_d = 1'b1;
      state_d   = ST_IDLE;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if ((chk_err_d || timeout_d) && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
  end

  assign o_cmd_vld = cmd_vld_q;
  assign o_cmd     = cmd_q;
  assign o_addr    = addr_q;
  assign o_wdata   = wdata_q;
  assign o_chk_err = chk_err_q;
  assign o_timeout = timeout_q;
  assign o_err_cnt = err_cnt_q;
  assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed and randomized frames against two parser instances (long/short timeout, wide/narrow count).
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int TO_A = 1000;
  localparam int TO_B = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic [7:0] data = 8'h00;
  bit         sel = 1'b0;

  always #5 clk = ~clk;

  logic a_vld_i, b_vld_i;
  assign a_vld_i = vld & ~sel;
  assign b_vld_i = vld & sel;

  logic       a_cmd_vld, a_chk_err, a_timeout, a_busy;
  logic [7:0] a_cmd, a_addr, a_wdata, a_err_cnt;
  logic       b_cmd_vld, b_chk_err, b_timeout, b_busy;
  logic [7:0] b_cmd, b_addr, b_wdata;
  logic [1:0] b_err_cnt;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO_A), .ERR_CNT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .i_data_vld(a_vld_i), .i_rx_data(data),
    .o_cmd_vld(a_cmd_vld), .o_cmd(a_cmd), .o_addr(a_addr), .o_wdata(a_wdata),
    .o_chk_err(a_chk_err), .o_timeout(a_timeout), .o_err_cnt(a_err_cnt), .o_busy(a_busy));

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO_B), .ERR_CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .i_data_vld(b_vld_i), .i_rx_data(data),
    .o_cmd_vld(b_cmd_vld), .o_cmd(b_cmd), .o_addr(b_addr), .o_wdata(b_wdata),
    .o_chk_err(b_chk_err), .o_timeout(b_timeout), .o_err_cnt(b_err_cnt), .o_busy(b_busy));

  logic       obs_vld, obs_chk, obs_to, obs_busy;
  logic [7:0] obs_cmd, obs_addr, obs_wdata, obs_err;
  always_comb begin
    if (sel) begin
      obs_vld = b_cmd_vld; obs_chk = b_chk_err; obs_to = b_timeout; obs_busy = b_busy;
      obs_cmd = b_cmd; obs_addr = b_addr; obs_wdata = b_wdata; obs_err = {6'b0, b_err_cnt};
    end else begin
      obs_vld = a_cmd_vld; obs_chk = a_chk_err; obs_to = a_timeout; obs_busy = a_busy;
      obs_cmd = a_cmd; obs_addr = a_addr; obs_wdata = a_wdata; obs_err = a_err_cnt;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int seen_vld[2] = '{0, 0};
  int seen_chk[2] = '{0, 0};
  int seen_to[2]  = '{0, 0};
  always @(negedge clk) begin
    if (a_cmd_vld) seen_vld[0]++;
    if (b_cmd_vld) seen_vld[1]++;
    if (a_chk_err) seen_chk[0]++;
    if (b_chk_err) seen_chk[1]++;
    if (a_timeout) seen_to[0]++;
    if (b_timeout) seen_to[1]++;
  end

  int checks = 0;
  int failures = 0;

  // Frame-level reference model: bytes collected since SOF, held outputs and event counts per DUT.
  logic [7:0] q[$];
  logic [7:0] exp_cmd[2], exp_addr[2], exp_wdata[2];
  int exp_err[2];
  int err_max[2] = '{255, 3};
  int n_vld[2] = '{0, 0};
  int n_chk[2] = '{0, 0};
  int n_to[2]  = '{0, 0};
  int cap_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int s = 0; s < 2; s++) begin
      exp_cmd[s] = 8'h00; exp_addr[s] = 8'h00; exp_wdata[s] = 8'h00; exp_err[s] = 0;
    end
  endtask

  task automatic bump_err(input int s);
    if (exp_err[s] < err_max[s]) exp_err[s]++;
  endtask

  task automatic model_accept(input logic [7:0] b, output bit ev_vld, output bit ev_chk);
    int s = int'(sel);
    ev_vld = 1'b0;
    ev_chk = 1'b0;
    if (q.size() == 0) begin
      if (b == SOF_BYTE_DEFAULT) q.push_back(b);
    end else begin
      q.push_back(b);
      if (q.size() == FRAME_LEN) begin
        if ((q[1] ^ q[2] ^ q[3]) == q[4]) begin
          ev_vld = 1'b1;
          exp_cmd[s] = q[1]; exp_addr[s] = q[2]; exp_wdata[s] = q[3];
          n_vld[s]++;
        end else begin
          ev_chk = 1'b1;
          n_chk[s]++;
          bump_err(s);
        end
        q.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold_in, input int gap_in);
    bit ev_vld, ev_chk;
    int s = int'(sel);
    int hold = (hold_in == 0) ? int'($urandom_range(3, 12)) : hold_in;
    int gap  = (gap_in == 0) ? int'($urandom_range(1, 8)) : gap_in;
    @(negedge clk); vld = 1'b1; data = 8'($urandom);
    @(negedge clk); data = b;
    @(negedge clk);
    cap_cyc = cyc;
    model_accept(b, ev_vld, ev_chk);
    $display("dut%0d byte %02h cmd_vld=%0b chk_err=%0b busy=%0b err_cnt=%0d cmd=%02h addr=%02h wdata=%02h",
             s, b, obs_vld, obs_chk, obs_busy, obs_err, obs_cmd, obs_addr, obs_wdata);
    chk("cmd_vld", {31'b0, obs_vld}, {31'b0, ev_vld});
    chk("chk_err", {31'b0, obs_chk}, {31'b0, ev_chk});
    chk("no_timeout", {31'b0, obs_to}, 32'd0);
    chk("busy", {31'b0, obs_busy}, (q.size() != 0) ? 32'd1 : 32'd0);
    chk("err_cnt", {24'b0, obs_err}, exp_err[s]);
    chk("held_outs", {8'b0, obs_cmd, obs_addr, obs_wdata}, {8'b0, exp_cmd[s], exp_addr[s], exp_wdata[s]});
    @(negedge clk);
    chk("pulse_width", {30'b0, obs_vld, obs_chk}, 32'd0);
    repeat (hold - 3) @(negedge clk);
    vld = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                            input bit bad, input int hold);
    logic [7:0] ck = c ^ a ^ d;
    if (bad) ck = ck ^ 8'($urandom_range(1, 255));
    send_byte(SOF_BYTE_DEFAULT, hold, 0);
    send_byte(c, hold, 0);
    send_byte(a, hold, 0);
    send_byte(d, hold, 0);
    send_byte(ck, hold, 0);
  endtask

  task automatic wait_timeout();
    int s = int'(sel);
    int t = sel ? TO_B : TO_A;
    bit seen = 1'b0;
    int at = 0;
    for (int i = 0; i < t + 20 && !seen; i++) begin
      @(negedge clk);
      if (obs_to) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    q.delete();
    bump_err(s);
    n_to[s]++;
    $display("dut%0d timeout seen=%0b after=%0d cycles busy=%0b err_cnt=%0d", s, seen, at - cap_cyc, obs_busy, obs_err);
    chk("timeout_seen", {31'b0, seen}, 32'd1);
    chk("timeout_cycle", at - cap_cyc, t);
    chk("busy_after_to", {31'b0, obs_busy}, 32'd0);
    chk("err_after_to", {24'b0, obs_err}, exp_err[s]);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a"}, {5'b0, a_cmd_vld, a_cmd, a_addr, a_wdata, a_chk_err, a_timeout, a_busy}, 32'd0);
    chk({tag, "_b"}, {5'b0, b_cmd_vld, b_cmd, b_addr, b_wdata, b_chk_err, b_timeout, b_busy}, 32'd0);
    chk({tag, "_errcnt"}, {22'b0, a_err_cnt, b_err_cnt}, 32'd0);
  endtask

  int sat_tbl[5] = '{1, 2, 3, 3, 3};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 1: good frame with a long valid level
    sel = 1'b0;
    send_frame(CMD_WR, 8'h10, 8'h3C, 1'b0, 651);
    // 2: bad checksum keeps previous outputs
    send_byte(8'hA5, 0, 0); send_byte(8'h01, 0, 0); send_byte(8'h10, 0, 0);
    send_byte(8'h3C, 0, 0); send_byte(8'h2E, 0, 0);
    // 3: garbage in IDLE, then a good frame
    send_byte(8'h00, 0, 0); send_byte(8'hFF, 0, 0); send_byte(8'h5A, 0, 0);
    send_byte(8'hA5, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'h20, 0, 0);
    send_byte(8'h00, 0, 0); send_byte(8'h22, 0, 0);

    // 4: partial frame times out, next frame decodes
    sel = 1'b1;
    send_byte(8'hA5, 0, 0); send_byte(8'h01, 0, 0);
    wait_timeout();
    send_frame(CMD_RD, 8'h44, 8'h55, 1'b0, 0);

    // 5: reset while the ADDR byte's valid is high
    send_byte(8'hA5, 0, 0); send_byte(8'h01, 0, 0);
    @(negedge clk); vld = 1'b1; data = 8'hA5;
    @(negedge clk); rst = 1'b1;
    #1;
    model_reset();
    check_all_zero("mid_frame_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_byte_after_rst", {30'b0, b_busy, b_cmd_vld}, 32'd0);
    vld = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'h33, 8'h66, 8'h99, 1'b0, 0);

    // 6: narrow error counter saturates
    for (int i = 0; i < 5; i++) begin
      send_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 0);
      chk("err_sat", {30'b0, b_err_cnt}, sat_tbl[i]);
    end

    // randomized frames, garbage and timeouts on both instances
    for (int it = 0; it < 30; it++) begin
      int kind;
      sel = bit'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 9));
      if (kind < 2) begin
        logic [7:0] g = 8'($urandom);
        if (g == SOF_BYTE_DEFAULT) g = g ^ 8'h01;
        send_byte(g, 0, 0);
      end else if (kind < 9) begin
        logic [7:0] c = $urandom_range(0, 1) ? CMD_WR : CMD_RD;
        if ($urandom_range(0, 3) == 0) c = 8'($urandom);
        send_frame(c, 8'($urandom), 8'($urandom), kind >= 7, 0);
      end else begin
        int extra = int'($urandom_range(0, 3));
        send_byte(SOF_BYTE_DEFAULT, 0, 0);
        for (int k = 0; k < extra; k++) send_byte(8'($urandom), 0, 0);
        wait_timeout();
      end
    end

    repeat (5) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("total_cmd_vld", seen_vld[s], n_vld[s]);
      chk("total_chk_err", seen_chk[s], n_chk[s]);
      chk("total_timeout", seen_to[s], n_to[s]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
